// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit seven-segment scanner: segment patterns,
// digit-enable codes, mode encodings and the registered display payload.
// No ports (package).
package seg7_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned AN_W   = 2;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned MODE_W = 2;

  // Active-low segment patterns {g,f,e,d,c,b,a}.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Digit 0 is the rightmost entry, digit 9 the leftmost.
  localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Active-low digit enables.
  localparam logic [AN_W-1:0] AN_ONES = 2'b10;
  localparam logic [AN_W-1:0] AN_TENS = 2'b01;
  localparam logic [AN_W-1:0] AN_OFF  = 2'b11;

  // Operating mode reported by the upstream adder/counter.
  typedef enum logic [MODE_W-1:0] {
    MODE_ADD   = 2'b00,
    MODE_HOLD  = 2'b01,
    MODE_COUNT = 2'b10
  } mode_e;

  // Everything that leaves the block toward the display pins.
  typedef struct packed {
    logic [SEG_W-1:0] seg;
    logic [AN_W-1:0]  an;
    logic             dp;
  } disp_t;

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Ports:
//   digit  - 4-bit digit value; 10..15 decode to blank
//   seg_c  - active-low segments {g,f,e,d,c,b,a}
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [DIG_W-1:0] digit,
  output logic [SEG_W-1:0] seg_c
);

  // Table lookup, blank for non-decimal codes.
  always_comb begin
    seg_c = SEG_BLANK;
    if (digit < DIG_W'(10)) begin
      seg_c = SEG_TABLE[digit];
    end
  end

endmodule

// File: rtl/seg_scan_disp.sv
// Two-digit multiplexed seven-segment display driver for a 0..15 result word,
// with leading-zero blanking, a hold-mode decimal point and an optional
// running-maximum register (enabled by defining PEAK_HOLD_EN).
// Parameters:
//   SCAN_DIV - clock cycles each digit stays lit (1..65535)
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-low reset
//   din  - value to display (0..15)
//   sel  - mode (00 add, 01 hold, 10 count)
//   seg  - active-low segments {g,f,e,d,c,b,a}
//   an   - active-low digit enables, an[0] ones, an[1] tens
//   dp   - active-low decimal point, lit on the tens digit in hold mode
//   peak - largest captured din since reset (0 when PEAK_HOLD_EN undefined)
module seg_scan_disp
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIG_W-1:0] din,
  input  logic [1:0]       sel,
  output logic [SEG_W-1:0] seg,
  output logic [AN_W-1:0]  an,
  output logic             dp,
  output logic [DIG_W-1:0] peak
);

  localparam int unsigned DIV_W = 16;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIG_W-1:0] disp_val;
  mode_e            mode_r;
  logic [DIV_W-1:0] div_cnt;
  logic             dsel;
  disp_t            disp_q;

  logic             tens_c;
  logic [DIG_W-1:0] ones_c;
  logic [DIG_W-1:0] dig_c;
  logic [SEG_W-1:0] dec_seg_c;
  disp_t            disp_c;

  // Split the captured value into decimal digits and pick the active slot.
  always_comb begin
    tens_c = (disp_val >= DIG_W'(10));
    ones_c = tens_c ? (disp_val - DIG_W'(10)) : disp_val;
    dig_c  = dsel ? DIG_W'(tens_c) : ones_c;
  end

  seg7_dec u_dec (
    .digit (dig_c),
    .seg_c (dec_seg_c)
  );

  // Next display word; the tens slot blanks a leading zero but keeps its enable.
  always_comb begin
    disp_c.seg = dec_seg_c;
    disp_c.an  = AN_ONES;
    disp_c.dp  = 1'b1;
    if (dsel) begin
      disp_c.an = AN_TENS;
      disp_c.dp = (mode_r != MODE_HOLD);
      if (!tens_c) begin
        disp_c.seg = SEG_BLANK;
      end
    end
  end

  // Capture, scan divider and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      disp_val <= '0;
      mode_r   <= MODE_ADD;
      div_cnt  <= '0;
      dsel     <= 1'b0;
      disp_q   <= '{seg: SEG_BLANK, an: AN_OFF, dp: 1'b1};
    end else begin
      disp_val <= din;
      mode_r   <= mode_e'(sel);
      disp_q   <= disp_c;
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        dsel    <= ~dsel;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  assign seg = disp_q.seg;
  assign an  = disp_q.an;
  assign dp  = disp_q.dp;

`ifdef PEAK_HOLD_EN
  logic [DIG_W-1:0] peak_q;

  // Running maximum; 4-bit input caps it at 15 naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      peak_q <= '0;
    end else if (din > peak_q) begin
      peak_q <= din;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_seg_scan_disp.sv
// Self-checking bench for seg_scan_disp (SCAN_DIV = 4): a directed vector
// table, hand-written corner sequences, and randomized traffic, all compared
// against a time-indexed reference model. Builds with or without PEAK_HOLD_EN.
module tb_seg_scan_disp;

  localparam int SCAN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic [1:0] sel;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;
  logic [3:0] peak;

  int n_chk  = 0;
  int n_fail = 0;

  // Inputs applied at every non-reset edge since the last reset, oldest first.
  logic [3:0] dq[$];
  logic [1:0] sq[$];

  typedef struct {
    logic [3:0] din;
    logic [1:0] sel;
    logic       rst;
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;
  } vec_t;

  vec_t tbl[$];

  seg_scan_disp #(.SCAN_DIV(SCAN)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .sel  (sel),
    .seg  (seg),
    .an   (an),
    .dp   (dp),
    .peak (peak)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'h40;
      1: pat = 7'h79;
      2: pat = 7'h24;
      3: pat = 7'h30;
      4: pat = 7'h19;
      5: pat = 7'h12;
      6: pat = 7'h02;
      7: pat = 7'h78;
      8: pat = 7'h00;
      9: pat = 7'h10;
      default: pat = 7'h7F;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge with the given inputs, then compare against the model.
  task automatic tick(input logic [3:0] d, input logic [1:0] s, input logic r);
    int k, v, m, slot, pk;
    logic [6:0] es;
    logic [1:0] ea;
    logic       edp;
    din = d;
    sel = s;
    rst = r;
    @(posedge clk);
    #1;
    pk = 0;
    if (!r) begin
      dq.delete();
      sq.delete();
      es  = 7'h7F;
      ea  = 2'b11;
      edp = 1'b1;
    end else begin
      k = dq.size() + 1;
      v = (k == 1) ? 0 : int'(dq[k-2]);
      m = (k == 1) ? 0 : int'(sq[k-2]);
      dq.push_back(d);
      sq.push_back(s);
      slot = ((k - 1) / SCAN) % 2;
      if (slot == 0) begin
        ea  = 2'b10;
        es  = pat(v % 10);
        edp = 1'b1;
      end else begin
        ea  = 2'b01;
        es  = (v / 10 == 0) ? 7'h7F : pat(v / 10);
        edp = (m == 1) ? 1'b0 : 1'b1;
      end
`ifdef PEAK_HOLD_EN
      foreach (dq[i]) if (int'(dq[i]) > pk) pk = int'(dq[i]);
`endif
    end
    chk("model_seg", int'(seg), int'(es));
    chk("model_an", int'(an), int'(ea));
    chk("model_dp", int'(dp), int'(edp));
    chk("model_peak", int'(peak), pk);
  endtask

  task automatic addv(input logic [3:0] d, input logic [1:0] s, input logic r,
                      input logic [6:0] es, input logic [1:0] ea, input logic edp,
                      input int n);
    for (int i = 0; i < n; i++) tbl.push_back('{d, s, r, es, ea, edp});
  endtask

  int pk_exp[4];
  logic [3:0] pk_din[4];

  initial begin
    rst = 1'b0;
    din = 4'd0;
    sel = 2'd0;

    // Directed table starting from reset.
    addv(4'd0,  2'd0, 1'b0, 7'h7F, 2'b11, 1'b1, 1);
    addv(4'd0,  2'd0, 1'b1, 7'h40, 2'b10, 1'b1, 4);
    addv(4'd0,  2'd0, 1'b1, 7'h7F, 2'b01, 1'b1, 4);
    addv(4'd15, 2'd0, 1'b1, 7'h40, 2'b10, 1'b1, 1);
    addv(4'd15, 2'd0, 1'b1, 7'h12, 2'b10, 1'b1, 3);
    addv(4'd15, 2'd0, 1'b1, 7'h79, 2'b01, 1'b1, 4);
    addv(4'd7,  2'd1, 1'b1, 7'h12, 2'b10, 1'b1, 1);
    addv(4'd7,  2'd1, 1'b1, 7'h78, 2'b10, 1'b1, 3);
    addv(4'd7,  2'd1, 1'b1, 7'h7F, 2'b01, 1'b0, 4);
    addv(4'd7,  2'd2, 1'b1, 7'h78, 2'b10, 1'b1, 4);
    addv(4'd7,  2'd2, 1'b1, 7'h7F, 2'b01, 1'b1, 4);
    foreach (tbl[i]) begin
      tick(tbl[i].din, tbl[i].sel, tbl[i].rst);
      chk("tbl_seg", int'(seg), int'(tbl[i].seg));
      chk("tbl_an", int'(an), int'(tbl[i].an));
      chk("tbl_dp", int'(dp), int'(tbl[i].dp));
    end

    // 9 then 10 changed mid tens slot: divider phase must not move.
    tick(4'd0, 2'd0, 1'b0);
    for (int i = 0; i < 6; i++) tick(4'd9, 2'd0, 1'b1);
    chk("mid_nine_blank", int'(seg), 7'h7F);
    tick(4'd10, 2'd0, 1'b1);
    chk("mid_still_blank", int'(seg), 7'h7F);
    chk("mid_still_tens", int'(an), 2'b01);
    tick(4'd10, 2'd0, 1'b1);
    chk("mid_tens_one", int'(seg), 7'h79);
    chk("mid_tens_an", int'(an), 2'b01);
    tick(4'd10, 2'd0, 1'b1);
    chk("mid_phase_an", int'(an), 2'b10);
    chk("mid_ones_zero", int'(seg), 7'h40);

    // Peak tracking sequence.
    pk_din = '{4'd3, 4'd12, 4'd5, 4'd0};
`ifdef PEAK_HOLD_EN
    pk_exp = '{3, 12, 12, 12};
`else
    pk_exp = '{0, 0, 0, 0};
`endif
    tick(4'd0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(pk_din[i], 2'd0, 1'b1);
      chk("peak_seq", int'(peak), pk_exp[i]);
    end

    // Reset pulse in the middle of the tens slot.
    tick(4'd0, 2'd0, 1'b0);
    for (int i = 0; i < 6; i++) tick(4'd8, 2'd1, 1'b1);
    chk("pre_rst_tens", int'(an), 2'b01);
    tick(4'd8, 2'd1, 1'b0);
    chk("rst_seg", int'(seg), 7'h7F);
    chk("rst_an", int'(an), 2'b11);
    chk("rst_peak", int'(peak), 0);
    for (int i = 0; i < SCAN; i++) begin
      tick(4'd8, 2'd1, 1'b1);
      chk("rst_ones_restart", int'(an), 2'b10);
    end
    tick(4'd8, 2'd1, 1'b1);
    chk("rst_then_tens", int'(an), 2'b01);
    chk("rst_then_dp", int'(dp), 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      tick(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 39) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_disp.md
SEG_SCAN_DISP -- requirements
Module: seg_scan_disp

Interface
REQ-001 The parameter list SHALL be: SCAN_DIV, 4, clock cycles each digit stays lit (legal range 1..65535).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-low.
REQ-004 The block SHALL have port din, input, 4 bits, the result word from count_hold_add dout (0..15).
REQ-005 The block SHALL have port sel, input, 2 bits, the mode from count_hold_add (00 add, 01 hold, 10 count).
REQ-006 The block SHALL have port seg, output, 7 bits, active-low segments {g,f,e,d,c,b,a}.
REQ-007 The block SHALL have port an, output, 2 bits, active-low digit enables: an[0] is the ones digit, an[1] is the tens digit.
REQ-008 The block SHALL have port dp, output, 1 bit, the active-low decimal point.
REQ-009 The block SHALL have port peak, output, 4 bits, the maximum captured value since reset.

Function
REQ-010 Each non-reset edge SHALL capture din into disp_val and sel into mode_r, with 1 cycle latency.
REQ-011 The digit split SHALL be: tens = 1 if disp_val >= 10, else 0; ones = disp_val - 10*tens.
REQ-012 The divider div_cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; on the wrapping edge the digit pointer dsel SHALL toggle.
REQ-013 With SCAN_DIV = 1, dsel SHALL toggle on every edge.
REQ-014 seg, an and dp SHALL be registered and computed from the pre-edge dsel, disp_val and mode_r.
REQ-015 This gives a total latency from din to seg of 2 edges.
REQ-016 With dsel = 0: an = 2'b10, seg = decode(ones), dp = 1.
REQ-017 With dsel = 1: an = 2'b01, seg = decode(tens), dp = 0 iff mode_r = 2'b01 (hold indicator), else 1.
REQ-018 Leading-zero blanking: when tens = 0, the tens slot SHALL drive seg = 7'h7F while an stays asserted.
REQ-019 The decode SHALL cover digits 0..9 using standard active-low patterns: 0 = 7'h40, 1 = 7'h79, 5 = 7'h12, 9 = 7'h10.
REQ-020 Input changes mid-slot SHALL appear in the next registered output and SHALL NOT restart the divider.

Reset
REQ-021 While rst = 0 at an edge, the block SHALL set: disp_val = 0, mode_r = 2'b00, div_cnt = 0, dsel = 0, seg = 7'h7F, an = 2'b11, dp = 1, peak = 0.
REQ-022 Reset asserted mid-scan SHALL take effect at the next edge and SHALL abandon the current slot.
REQ-023 The first edge after release SHALL show the ones slot (an = 2'b10) for SCAN_DIV cycles.

Configuration
REQ-024 With PEAK_HOLD_EN defined, each non-reset edge SHALL set peak <= max(peak, din), with 1 cycle latency; peak saturates at 15.
REQ-025 With PEAK_HOLD_EN undefined, peak SHALL be constant 4'h0 and the peak register SHALL be absent.

Structure
REQ-026 Package seg7_pkg SHALL hold: the digit-to-segment constant table, SEG_BLANK = 7'h7F, and the AN_ONES = 2'b10 / AN_TENS = 2'b01 constants.
REQ-027 The mode encodings MODE_ADD, MODE_HOLD and MODE_COUNT SHALL also live in seg7_pkg.
REQ-028 Sub-module seg7_dec SHALL be the combinational 4-bit to 7-bit decoder; it is instantiated once, fed by the slot mux.

Verification
REQ-029 Reset then release, din = 0, SCAN_DIV = 4 -> an = 10 with seg = 40 for 4 cycles, then an = 01 with seg = 7F for 4 cycles, repeating.
REQ-030 din = 4'd15, sel = 00 -> ones slot seg = 12 (5), tens slot seg = 79 (1), dp = 1 throughout.
REQ-031 din = 4'd9 then 4'd10 at a slot midpoint -> first 9 with blank tens, then 0 / 1 two edges after the change; divider phase is unchanged.
REQ-032 sel = 01 with din = 7 held -> dp = 0 only while an = 01; sel = 10 -> dp = 1 always.
REQ-033 PEAK_HOLD_EN defined, din sequence 3, 12, 5, 0 -> peak = 3, 12, 12, 12; with the macro undefined, peak = 0.
REQ-034 rst = 0 for one edge mid-tens-slot -> seg = 7F, an = 11, peak = 0 that edge, then the ones slot restarts.
